// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts, op-bit indices,
// divider states and the ALU datapath.
package exe_stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [11:0] alu_op;
        logic [3:0]  div_op;
        logic [4:0]  load_op;
        logic [2:0]  store_op;
        logic [31:0] rkd_value;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } ds_to_es_t;

    localparam int DS_TO_ES_BUS_WD = $bits(ds_to_es_t);
    localparam int ES_TO_MS_BUS_WD = 76;
    localparam int ES_FWD_BUS_WD   = 39;

    // alu_op one-hot bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam int DIV_W  = 0;
    localparam int MOD_W  = 1;
    localparam int DIV_WU = 2;
    localparam int MOD_WU = 3;

    localparam int ST_B = 0;
    localparam int ST_H = 1;
    localparam int ST_W = 2;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (op[ALU_ADD])  r |= a + b;
        if (op[ALU_SUB])  r |= a - b;
        if (op[ALU_SLT])  r |= {31'b0, $signed(a) < $signed(b)};
        if (op[ALU_SLTU]) r |= {31'b0, a < b};
        if (op[ALU_AND])  r |= a & b;
        if (op[ALU_NOR])  r |= ~(a | b);
        if (op[ALU_OR])   r |= a | b;
        if (op[ALU_XOR])  r |= a ^ b;
        if (op[ALU_SLL])  r |= a << b[4:0];
        if (op[ALU_SRL])  r |= a >> b[4:0];
        if (op[ALU_SRA])  r |= 32'($signed(a) >>> b[4:0]);
        if (op[ALU_LUI])  r |= b;
        return r;
    endfunction

endpackage

// File: rtl/exe_stage_div_radix2.sv
// Iterative restoring divider: one quotient bit per cycle, signs applied on
// the unsigned magnitudes once the last step is done.
module exe_stage_div_radix2
    import exe_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ack,
    input  logic         flush,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    div_state_e    state;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  divisor;
    logic [W-1:0]  a_raw;
    logic          sign_q;
    logic          sign_r;
    logic          b_zero;
    logic [CW-1:0] cnt;

    logic          a_neg;
    logic          b_neg;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    assign a_neg   = signed_op & a[W-1];
    assign b_neg   = signed_op & b[W-1];
    assign shifted = {rem, quo[W-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = shifted >= {1'b0, divisor};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= DIV_IDLE;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            a_raw   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            b_zero  <= 1'b0;
            cnt     <= '0;
        end else if (flush) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    state   <= DIV_BUSY;
                    quo     <= a_neg ? -a : a;
                    divisor <= b_neg ? -b : b;
                    rem     <= '0;
                    a_raw   <= a;
                    b_zero  <= (b == '0);
                    sign_q  <= a_neg ^ b_neg;
                    sign_r  <= a_neg;
                    cnt     <= '0;
                end
                DIV_BUSY: begin
                    // dividend bits shift out of quo as quotient bits shift in
                    rem <= fits ? diff[W-1:0] : shifted[W-1:0];
                    quo <= {quo[W-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= DIV_DONE;
                end
                DIV_DONE: if (ack) state <= DIV_IDLE;
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign done      = (state == DIV_DONE);
    // divide-by-zero bypasses the sign fix-up entirely
    assign quotient  = b_zero ? '1    : (sign_q ? -quo : quo);
    assign remainder = b_zero ? a_raw : (sign_r ? -rem : rem);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative divide, data-SRAM request issue, and the
// forwarding/stall bus back to decode.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FWD_BUS_WD = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [FWD_BUS_WD-1:0]      es_fwd_bus,
    input  logic                       es_flush_pipe,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    ds_to_es_t   es;
    logic        es_valid;
    logic        es_ready_go;
    logic        is_div;
    logic        div_signed;
    logic        div_sel_quo;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic        mem_op;
    logic [3:0]  byte_en;
    logic        fwd_valid;
    logic        fwd_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
            es       <= '0;
        end else begin
            if (es_flush_pipe)   es_valid <= 1'b0;
            else if (es_allowin) es_valid <= ds_to_es_valid;
            if (ds_to_es_valid && es_allowin) es <= ds_to_es_t'(ds_to_es_bus);
        end
    end

    assign is_div      = |es.div_op;
    assign div_signed  = es.div_op[DIV_W] | es.div_op[MOD_W];
    assign div_sel_quo = es.div_op[DIV_W] | es.div_op[DIV_WU];

    assign es_ready_go    = !is_div || div_done;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go && !es_flush_pipe;

    exe_stage_div_radix2 #(.W(DATA_W)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (es_valid & is_div),
        .signed_op (div_signed),
        .a         (es.src1),
        .b         (es.src2),
        .ack       (es_to_ms_valid & ms_allowin),
        .flush     (es_flush_pipe),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign alu_result = alu_calc(es.alu_op, es.src1, es.src2);
    assign es_result  = is_div ? (div_sel_quo ? div_quo : div_rem) : alu_result;

    // request only in the transfer cycle so rdata aligns with the op in MS
    assign mem_op       = (|es.load_op) | (|es.store_op);
    assign data_sram_en = es_valid && es_ready_go && ms_allowin && mem_op && !es_flush_pipe;

    always_comb begin
        byte_en         = 4'b0000;
        data_sram_wdata = es.rkd_value;
        if (es.store_op[ST_B]) begin
            byte_en         = 4'b0001 << es_result[1:0];
            data_sram_wdata = {4{es.rkd_value[7:0]}};
        end else if (es.store_op[ST_H]) begin
            byte_en         = es_result[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{es.rkd_value[15:0]}};
        end else if (es.store_op[ST_W]) begin
            byte_en         = 4'b1111;
        end
    end

    assign data_sram_we   = data_sram_en ? byte_en : 4'b0000;
    assign data_sram_addr = {es_result[31:2], 2'b00};

    assign es_to_ms_bus = {es.load_op, es.res_from_mem, es.gr_we, es.dest, es_result, es.pc};

    assign fwd_valid  = es_valid & es.gr_we;
    assign fwd_stall  = fwd_valid & (es.res_from_mem | (is_div & !div_done));
    assign es_fwd_bus = {fwd_stall, fwd_valid, es.dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: handshake, ALU, divider, SRAM request,
// load back-pressure, flush and mid-division reset.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       resetn;
    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus;
    logic                       es_flush_pipe;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_we;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;

    int checks = 0;
    int failures = 0;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_fwd_bus      (es_fwd_bus),
        .es_flush_pipe   (es_flush_pipe),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] OP_ADD = 12'h001;

    function automatic ds_to_es_t mk(input logic [11:0] aop, input logic [3:0] dop,
                                     input logic [4:0] lop, input logic [2:0] sop,
                                     input logic [31:0] s1, input logic [31:0] s2,
                                     input logic [31:0] rkd, input logic [4:0] dest);
        ds_to_es_t b;
        b.pc           = 32'h1c00_0000 + {27'b0, dest} * 4;
        b.src1         = s1;
        b.src2         = s2;
        b.alu_op       = aop;
        b.div_op       = dop;
        b.load_op      = lop;
        b.store_op     = sop;
        b.rkd_value    = rkd;
        b.res_from_mem = |lop;
        b.gr_we        = ~|sop;
        b.dest         = dest;
        return b;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ms_allowin = 1'b1; ds_to_es_valid = 1'b0;
        ds_to_es_bus = '0; es_flush_pipe = 1'b0;
        #2;
        checks++; if (es_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", es_allowin); end
        checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL reset_ms_valid got=%b exp=0", es_to_ms_valid); end
        checks++; if (es_fwd_bus !== '0) begin failures++; $display("FAIL reset_fwd got=%h exp=0", es_fwd_bus); end
        checks++; if (es_to_ms_bus !== '0) begin failures++; $display("FAIL reset_ms_bus got=%h exp=0", es_to_ms_bus); end
        checks++; if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== '0) begin
            failures++; $display("FAIL reset_sram got en=%b we=%b addr=%h wdata=%h exp=all zero",
                                 data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
        end
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_add();
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(OP_ADD, 4'b0, 5'b0, 3'b0, 32'd5, 32'd7, 32'd0, 5'd3);
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", es_to_ms_valid); end
        checks++; if (es_to_ms_bus[63:32] !== 32'd12) begin failures++; $display("FAIL add_result got=%h exp=0000000c", es_to_ms_bus[63:32]); end
        checks++; if (es_to_ms_bus[31:0] !== 32'h1c00_000c) begin failures++; $display("FAIL add_pc got=%h exp=1c00000c", es_to_ms_bus[31:0]); end
        checks++; if (es_fwd_bus !== {1'b0, 1'b1, 5'd3, 32'd12}) begin failures++; $display("FAIL add_fwd got=%h exp=%h", es_fwd_bus, {1'b0, 1'b1, 5'd3, 32'd12}); end
        checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL add_no_sram got=%b exp=0", data_sram_en); end
        step();
        checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL add_drained got=%b exp=0", es_to_ms_valid); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ops [11];
        logic [31:0] s1 [11];
        logic [31:0] s2 [11];
        logic [31:0] ex [11];
        ops = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040, 12'h080, 12'h100, 12'h200, 12'h400, 12'h800};
        s1  = '{32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0, 32'h00F0, 32'h0FF0, 32'd1, 32'h80000000, 32'h80000000, 32'h0};
        s2  = '{32'd3, 32'd1, 32'd1, 32'h0000FF00, 32'h0, 32'h0F00, 32'h00FF, 32'd4, 32'd4, 32'd4, 32'h12345000};
        ex  = '{32'd7, 32'd1, 32'd0, 32'h0000F000, 32'hFFFFFFFF, 32'h0FF0, 32'h0F0F, 32'd16, 32'h08000000, 32'hF8000000, 32'h12345000};
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(ops[0], 4'b0, 5'b0, 3'b0, s1[0], s2[0], 32'd0, 5'd1);
        step();
        for (int i = 0; i < 11; i++) begin
            if (i < 10) ds_to_es_bus = mk(ops[i+1], 4'b0, 5'b0, 3'b0, s1[i+1], s2[i+1], 32'd0, 5'd1);
            else        ds_to_es_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== ex[i]) begin
                failures++; $display("FAIL b2b_op%0d got valid=%b result=%h exp valid=1 result=%h", i, es_to_ms_valid, es_to_ms_bus[63:32], ex[i]);
            end
            step();
        end
    endtask

    task automatic run_div(input string name, input logic [3:0] dop,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int stalls = 0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h0, dop, 5'b0, 3'b0, a, b, 32'd0, 5'd9);
        step();
        ds_to_es_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (es_to_ms_valid) break;
            if (es_fwd_bus[38]) stalls++;
            step();
        end
        checks++; if (es_to_ms_valid !== 1'b1) begin failures++; $display("FAIL %s_timeout got valid=%b exp=1 within 40 cycles", name, es_to_ms_valid); end
        checks++; if (stalls !== 33) begin failures++; $display("FAIL %s_stalls got=%0d exp=33", name, stalls); end
        checks++; if (es_to_ms_bus[63:32] !== exp) begin failures++; $display("FAIL %s_result got=%h exp=%h", name, es_to_ms_bus[63:32], exp); end
        step();
    endtask

    task automatic test_div();
        run_div("div_w_neg",   4'b0001, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_div("mod_w_neg",   4'b0010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_div("div_w_negb",  4'b0001, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        run_div("mod_w_negb",  4'b0010, 32'd7,        32'hFFFFFFFE, 32'd1);
        run_div("div_wu",      4'b0100, 32'd100,      32'd7,        32'd14);
        run_div("mod_wu",      4'b1000, 32'd100,      32'd7,        32'd2);
        run_div("div_wu_zero", 4'b0100, 32'd9,        32'd0,        32'hFFFFFFFF);
        run_div("mod_wu_zero", 4'b1000, 32'd9,        32'd0,        32'd9);
        run_div("mod_w_zero",  4'b0010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
        run_div("div_w_ovf",   4'b0001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("mod_w_ovf",   4'b0010, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    endtask

    task automatic test_store();
        logic [2:0]  sop  [3];
        logic [31:0] base [3];
        logic [31:0] off  [3];
        logic [31:0] rkd  [3];
        logic [3:0]  we   [3];
        logic [31:0] addr [3];
        logic [31:0] wd   [3];
        sop  = '{3'b010, 3'b001, 3'b100};
        base = '{32'h1000, 32'h2000, 32'h3000};
        off  = '{32'd2, 32'd3, 32'd0};
        rkd  = '{32'hABCD1234, 32'h556677EF, 32'hCAFEF00D};
        we   = '{4'b1100, 4'b1000, 4'b1111};
        addr = '{32'h1000, 32'h2000, 32'h3000};
        wd   = '{32'h12341234, 32'hEFEFEFEF, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = mk(OP_ADD, 4'b0, 5'b0, sop[i], base[i], off[i], rkd[i], 5'd0);
            @(negedge clk);
            checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL st%0d_early_en got=%b exp=0", i, data_sram_en); end
            step();
            ds_to_es_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (data_sram_en !== 1'b1 || data_sram_we !== we[i] || data_sram_addr !== addr[i] || data_sram_wdata !== wd[i]) begin
                failures++; $display("FAIL st%0d_req got en=%b we=%b addr=%h wdata=%h exp en=1 we=%b addr=%h wdata=%h",
                                     i, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, we[i], addr[i], wd[i]);
            end
            step();
            checks++;
            if (data_sram_en !== 1'b0 || data_sram_we !== 4'b0) begin
                failures++; $display("FAIL st%0d_after got en=%b we=%b exp en=0 we=0000", i, data_sram_en, data_sram_we);
            end
        end
    endtask

    task automatic test_load_stall();
        int en_count = 0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(OP_ADD, 4'b0, 5'b00001, 3'b0, 32'h400, 32'd4, 32'd0, 5'd6);
        step();
        ms_allowin   = 1'b0;
        ds_to_es_bus = mk(OP_ADD, 4'b0, 5'b0, 3'b0, 32'd20, 32'd22, 32'd0, 5'd7);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            en_count += int'(data_sram_en);
            checks++;
            if (es_allowin !== 1'b0 || data_sram_en !== 1'b0 || es_to_ms_bus[63:32] !== 32'h404 || es_fwd_bus[38:37] !== 2'b11) begin
                failures++; $display("FAIL ld_hold%0d got allowin=%b en=%b result=%h stall,valid=%b exp allowin=0 en=0 result=00000404 stall,valid=11",
                                     c, es_allowin, data_sram_en, es_to_ms_bus[63:32], es_fwd_bus[38:37]);
            end
            step();
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        en_count += int'(data_sram_en);
        checks++;
        if (es_allowin !== 1'b1 || data_sram_addr !== 32'h404 || data_sram_we !== 4'b0) begin
            failures++; $display("FAIL ld_release got allowin=%b addr=%h we=%b exp allowin=1 addr=00000404 we=0000", es_allowin, data_sram_addr, data_sram_we);
        end
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        en_count += int'(data_sram_en);
        checks++; if (es_to_ms_bus[63:32] !== 32'd42) begin failures++; $display("FAIL ld_next_result got=%h exp=0000002a", es_to_ms_bus[63:32]); end
        step();
        @(negedge clk);
        en_count += int'(data_sram_en);
        checks++; if (en_count !== 1) begin failures++; $display("FAIL ld_en_once got=%0d exp=1", en_count); end
        step();
    endtask

    task automatic test_flush();
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h0, 4'b0001, 5'b0, 3'b0, 32'd100, 32'd3, 32'd0, 5'd4);
        step();
        ds_to_es_valid = 1'b0;
        repeat (10) step();
        es_flush_pipe = 1'b1;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0 || data_sram_en !== 1'b0) begin
            failures++; $display("FAIL flush_cycle got valid=%b en=%b exp valid=0 en=0", es_to_ms_valid, data_sram_en);
        end
        step();
        es_flush_pipe = 1'b0;
        @(negedge clk);
        checks++; if (es_allowin !== 1'b1 || es_fwd_bus[37] !== 1'b0) begin
            failures++; $display("FAIL flush_empty got allowin=%b fwd_valid=%b exp allowin=1 fwd_valid=0", es_allowin, es_fwd_bus[37]);
        end
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(OP_ADD, 4'b0, 5'b0, 3'b0, 32'd1, 32'd2, 32'd0, 5'd5);
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd3) begin
            failures++; $display("FAIL flush_add got valid=%b result=%h exp valid=1 result=00000003", es_to_ms_valid, es_to_ms_bus[63:32]);
        end
        step();
        run_div("div_after_flush", 4'b0001, 32'd100, 32'd3, 32'd33);
        // flushing a load in its would-be transfer cycle must suppress the request
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(OP_ADD, 4'b0, 5'b00001, 3'b0, 32'h800, 32'd0, 32'd0, 5'd8);
        step();
        ds_to_es_valid = 1'b0;
        es_flush_pipe  = 1'b1;
        @(negedge clk);
        checks++; if (data_sram_en !== 1'b0 || es_to_ms_valid !== 1'b0) begin
            failures++; $display("FAIL flush_load got en=%b valid=%b exp en=0 valid=0", data_sram_en, es_to_ms_valid);
        end
        step();
        es_flush_pipe = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL flush_load_gone got=%b exp=0", es_to_ms_valid); end
        step();
    endtask

    task automatic test_reset_mid_div();
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h0, 4'b0100, 5'b0, 3'b0, 32'd50, 32'd5, 32'd0, 5'd2);
        step();
        ds_to_es_valid = 1'b0;
        repeat (5) step();
        #2 resetn = 1'b0;
        #1;
        checks++; if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 || data_sram_en !== 1'b0 || es_fwd_bus !== '0) begin
            failures++; $display("FAIL rst_mid_div got valid=%b allowin=%b en=%b fwd=%h exp 0,1,0,0", es_to_ms_valid, es_allowin, data_sram_en, es_fwd_bus);
        end
        step();
        resetn = 1'b1;
        step();
        run_div("div_after_reset", 4'b1000, 32'd100, 32'd7, 32'd2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_div();
        test_store();
        test_load_stall();
        test_flush();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
